cpu_run_monitor: RTL and testbench

- Synthesizable run controller and writeback tracer for the 5-stage pipelined CPU.
- Sequences CPU reset, counts cycles and retired writebacks, detects halt (PC spinning on itself) or timeout, and keeps a shadow register file.
- Buffers the writeback stream in a trace FIFO that is drained over a valid/ready port.
- Replaces fixed-time, print-based run control with a reusable block usable in simulation and on FPGA.

---
 rtl/cpu_run_pkg.sv | 20 ++
 rtl/trace_fifo.sv | 64 ++++++
 rtl/cpu_run_monitor.sv | 171 +++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run monitor: run-state encoding and trace entry layout.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_HOLD = 3'd1,
        ST_RUN        = 3'd2,
        ST_DONE       = 3'd3,
        ST_TIMEOUT    = 3'd4
    } run_state_e;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_RW   = 4;

    typedef struct packed {
        logic [DEF_RW-1:0]   rd;
        logic [DEF_XLEN-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered head, wrap-bit pointers and sticky overflow flag.
module trace_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             overflow
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty, full, pop, push_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && pop_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop)                   rd_ptr_d   = rd_ptr_q + 1'b1;
            if (push_ok)               wr_ptr_d   = wr_ptr_q + 1'b1;
            if (push && full && !pop)  overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign valid    = !empty;
    assign head     = mem[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller and writeback tracer for the pipelined CPU.
// Define CPU_RUN_SIGNATURE_EN to add the rolling writeback signature output.
module cpu_run_monitor
    import cpu_run_pkg::*;
#(
    parameter  int unsigned XLEN         = 32,
    parameter  int unsigned NUM_REGS     = 16,
    parameter  int unsigned TRACE_DEPTH  = 16,
    parameter  int unsigned RESET_CYCLES = 4,
    parameter  int unsigned HALT_STABLE  = 8,
    parameter  int unsigned TIMEOUT      = 1024,
    parameter  int unsigned CW           = 32,
    localparam int unsigned RW           = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            cpu_reset,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            running,
    output logic            done,
    output logic            timeout,
    output logic [CW-1:0]   cycle_count,
    output logic [CW-1:0]   retire_count,
    input  logic [RW-1:0]   shadow_addr,
    output logic [XLEN-1:0] shadow_data,
    output logic            trace_valid,
    input  logic            trace_ready,
    output logic [RW-1:0]   trace_rd,
    output logic [XLEN-1:0] trace_data,
    output logic            trace_overflow
`ifdef CPU_RUN_SIGNATURE_EN
    ,
    output logic [XLEN-1:0] signature
`endif
);
    localparam int unsigned HW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned SW = $clog2(HALT_STABLE + 1);

    run_state_e      state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic [XLEN-1:0] pc_prev_q, pc_prev_d;
    logic            pc_seen_q, pc_seen_d;
    logic [CW-1:0]   cycle_q, cycle_d, retire_q, retire_d;
    logic [XLEN-1:0] shadow_q [NUM_REGS];
    logic [XLEN-1:0] shadow_d [NUM_REGS];
    logic            clr, capture, pc_match;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stable_d  = stable_q;
        pc_prev_d = pc_prev_q;
        pc_seen_d = pc_seen_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        clr       = 1'b0;
        capture   = (state_q == ST_RUN) && wb_en && (wb_rd != '0);
        // The first RUN cycle has no predecessor PC, so it never counts as a match.
        pc_match  = pc_seen_q && (pc == pc_prev_q);

        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    state_d   = ST_RESET_HOLD;
                    hold_d    = '0;
                    stable_d  = '0;
                    pc_seen_d = 1'b0;
                    cycle_d   = '0;
                    retire_d  = '0;
                    clr       = 1'b1;
                end
            end
            ST_RESET_HOLD: begin
                if (hold_q == HW'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                cycle_d   = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
                pc_prev_d = pc;
                pc_seen_d = 1'b1;
                stable_d  = pc_match ? stable_q + 1'b1 : '0;
                if (pc_match && (stable_d >= SW'(HALT_STABLE - 1))) state_d = ST_DONE;
                else if (cycle_d == CW'(TIMEOUT - 1))                  state_d = ST_TIMEOUT;
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) retire_d = (retire_q == '1) ? retire_q : retire_q + 1'b1;
    end

    always_comb begin
        shadow_d = shadow_q;
        if (clr) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) shadow_d[i] = '0;
        end else if (capture) begin
            shadow_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            stable_q  <= '0;
            pc_prev_q <= '0;
            pc_seen_q <= 1'b0;
            cycle_q   <= '0;
            retire_q  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stable_q  <= stable_d;
            pc_prev_q <= pc_prev_d;
            pc_seen_q <= pc_seen_d;
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
            shadow_q  <= shadow_d;
        end
    end

    trace_fifo #(
        .WIDTH (RW + XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .push      (capture),
        .push_data ({wb_rd, wb_data}),
        .pop_ready (trace_ready),
        .valid     (trace_valid),
        .head      ({trace_rd, trace_data}),
        .overflow  (trace_overflow)
    );

`ifdef CPU_RUN_SIGNATURE_EN
    logic [XLEN-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr)          sig_d = '0;
        else if (capture) sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ wb_data ^ XLEN'(wb_rd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign signature = sig_q;
`endif

    assign cpu_reset    = (state_q != ST_RUN);
    assign running      = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign timeout      = (state_q == ST_TIMEOUT);
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign shadow_data  = shadow_q[shadow_addr];

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized and directed bench for cpu_run_monitor against a PC-history / queue reference model.
module tb_cpu_run_monitor;
    import cpu_run_pkg::*;

    localparam int unsigned RESET_CYCLES = 4;
    localparam int unsigned HALT_STABLE  = 8;
    localparam int unsigned TIMEOUT      = 64;
    localparam int unsigned DEPTH        = 16;

    logic        clk = 1'b0;
    logic        reset, start, wb_en, trace_ready;
    logic [31:0] pc, wb_data;
    logic [3:0]  wb_rd, shadow_addr;
    logic        cpu_reset, running, done, timeout, trace_valid, trace_overflow;
    logic [31:0] cycle_count, retire_count, shadow_data, trace_data;
    logic [3:0]  trace_rd;
`ifdef CPU_RUN_SIGNATURE_EN
    logic [31:0] signature;
`endif

    cpu_run_monitor #(
        .XLEN         (32),
        .NUM_REGS     (16),
        .TRACE_DEPTH  (DEPTH),
        .RESET_CYCLES (RESET_CYCLES),
        .HALT_STABLE  (HALT_STABLE),
        .TIMEOUT      (TIMEOUT),
        .CW           (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cpu_reset      (cpu_reset),
        .pc             (pc),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .running        (running),
        .done           (done),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .retire_count   (retire_count),
        .shadow_addr    (shadow_addr),
        .shadow_data    (shadow_data),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_rd       (trace_rd),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow)
`ifdef CPU_RUN_SIGNATURE_EN
        ,
        .signature      (signature)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: run phase plus plain counters, a PC history and a trace queue.
    typedef enum {M_IDLE, M_HOLD, M_RUN, M_DONE, M_TO} mphase_e;
    mphase_e      m_phase;
    int unsigned  m_hold, m_cycles, m_retire;
    bit           m_ovf;
    logic [31:0]  m_shadow [16];
    logic [31:0]  m_sig;
    logic [31:0]  m_pcs [$];
    trace_entry_t m_fifo [$];

    int unsigned checks = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_hold = 0; m_cycles = 0; m_retire = 0; m_ovf = 0; m_sig = '0;
        for (int i = 0; i < 16; i++) m_shadow[i] = '0;
        m_pcs.delete();
        m_fifo.delete();
    endtask

    function automatic bit halted();
        int n = m_pcs.size();
        if (n < int'(HALT_STABLE)) return 1'b0;
        for (int k = 1; k < int'(HALT_STABLE); k++)
            if (m_pcs[n-1-k] != m_pcs[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit           pop, cap;
        trace_entry_t e;
        pop = (m_fifo.size() > 0) && trace_ready;
        cap = (m_phase == M_RUN) && wb_en && (wb_rd != 4'd0);
        if (pop) void'(m_fifo.pop_front());
        if (cap) begin
            m_shadow[wb_rd] = wb_data;
            m_retire++;
            e.rd = wb_rd; e.data = wb_data;
            if (m_fifo.size() < DEPTH) m_fifo.push_back(e);
            else                      m_ovf = 1'b1;
            m_sig = {m_sig[30:0], m_sig[31]} ^ wb_data ^ {28'd0, wb_rd};
        end
        case (m_phase)
            M_IDLE, M_DONE, M_TO: if (start) begin model_clear(); m_phase = M_HOLD; end
            M_HOLD: begin
                m_hold++;
                if (m_hold == RESET_CYCLES) m_phase = M_RUN;
            end
            M_RUN: begin
                m_cycles++;
                m_pcs.push_back(pc);
                if (halted())                     m_phase = M_DONE;
                else if (m_cycles == TIMEOUT - 1) m_phase = M_TO;
            end
        endcase
    endtask

    task automatic check_all();
        check("cpu_reset", 64'(cpu_reset), 64'(m_phase != M_RUN));
        check("running", 64'(running), 64'(m_phase == M_RUN));
        check("done", 64'(done), 64'(m_phase == M_DONE));
        check("timeout", 64'(timeout), 64'(m_phase == M_TO));
        check("cycle_count", 64'(cycle_count), 64'(m_cycles));
        check("retire_count", 64'(retire_count), 64'(m_retire));
        check("trace_valid", 64'(trace_valid), 64'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            check("trace_rd", 64'(trace_rd), 64'(m_fifo[0].rd));
            check("trace_data", 64'(trace_data), 64'(m_fifo[0].data));
        end
        check("trace_overflow", 64'(trace_overflow), 64'(m_ovf));
        check("shadow_data", 64'(shadow_data), 64'(m_shadow[shadow_addr]));
`ifdef CPU_RUN_SIGNATURE_EN
        check("signature", 64'(signature), 64'(m_sig));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic quiet();
        start = 0; wb_en = 0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic do_start();
        quiet(); start = 1; cycle(); start = 0;
        for (int i = 0; i < int'(RESET_CYCLES); i++) cycle();
    endtask

    initial begin
        reset = 0; quiet(); pc = '0; trace_ready = 0; shadow_addr = '0;
        m_phase = M_IDLE; model_clear();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1;
        cycle();

        // Incrementing PC with three writebacks (one to r0), then a spin at 0x40.
        do_start();
        check("running_after_hold", 64'(running), 64'd1);
        for (int i = 0; i < 16; i++) begin
            pc = 32'(i * 4); wb_en = 0;
            if (i == 2) begin wb_en = 1; wb_rd = 4'd1; wb_data = 32'h5;  end
            if (i == 4) begin wb_en = 1; wb_rd = 4'd0; wb_data = 32'hFF; end
            if (i == 6) begin wb_en = 1; wb_rd = 4'd2; wb_data = 32'hA;  end
            cycle();
        end
        wb_en = 0; pc = 32'h40;
        for (int i = 0; i < int'(HALT_STABLE); i++) cycle();
        check("done_after_spin", 64'(done), 64'd1);
        check("retire_two", 64'(retire_count), 64'd2);
        for (int i = 0; i < 3; i++) begin pc = 32'(i); cycle(); end
        trace_ready = 1;
        for (int a = 0; a < 16; a++) begin shadow_addr = 4'(a); cycle(); end
        trace_ready = 0;

        // Overflow: 20 writebacks with the consumer stalled, then run into timeout.
        do_start();
        for (int i = 0; i < 20; i++) begin
            pc = 32'h100 + 32'(i * 4); wb_en = 1; wb_rd = 4'((i % 15) + 1); wb_data = $urandom;
            cycle();
        end
        wb_en = 0;
        check("retire_twenty", 64'(retire_count), 64'd20);
        check("overflow_set", 64'(trace_overflow), 64'd1);
        for (int i = 20; i < 50 + 20; i++) begin pc = 32'h100 + 32'(i * 4); cycle(); end
        check("timeout_set", 64'(timeout), 64'd1);
        check("timeout_count", 64'(cycle_count), 64'(TIMEOUT - 1));
        trace_ready = 1;
        for (int i = 0; i < 18; i++) begin shadow_addr = 4'($urandom_range(15)); cycle(); end

        // Randomized runs, including stray starts that must be ignored mid-run.
        for (int r = 0; r < 6; r++) begin
            int stuck = 0;
            do_start();
            for (int i = 0; i < 90; i++) begin
                start = ($urandom_range(15) == 0);
                if (stuck > 0) stuck--;
                else if ($urandom_range(9) == 0) stuck = 4 + $urandom_range(8);
                else pc = 32'($urandom_range(7)) << 2;
                wb_en = $urandom_range(1); wb_rd = 4'($urandom_range(15)); wb_data = $urandom;
                trace_ready = ($urandom_range(3) != 0);
                shadow_addr = 4'($urandom_range(15));
                cycle();
            end
        end

        // Asynchronous reset in the middle of a run.
        trace_ready = 0;
        do_start();
        for (int i = 0; i < 20; i++) begin
            pc = 32'(i * 4); wb_en = 1; wb_rd = 4'($urandom_range(1, 15)); wb_data = $urandom;
            cycle();
        end
        quiet();
        reset = 0;
        m_phase = M_IDLE; model_clear();
        #1 check_all();
        @(negedge clk);
        reset = 1;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
